kband_lw_mem_arbiter: RTL and testbench

Two-port arbiter for the 8192×32 single-port on-chip memory on the lightweight bus segment. It shares the memory between the host lightweight bridge (requester 0) and the KBand core's parameter/result port (requester 1). Arbitration is sticky round-robin with a bounded hold. It presents an Avalon-MM slave face to each requester and drives the memory's single Avalon-MM slave port, which has a fixed read latency of 1 cycle.

---
 rtl/kband_lw_mem_pkg.sv | 21 ++
 rtl/kband_rr_hold_grant.sv | 62 ++++++
 rtl/kband_lw_mem_arbiter.sv | 115 +++++++++++
 tb/tb_kband_lw_mem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/kband_lw_mem_pkg.sv
// Shared types and defaults for the lightweight-bus memory arbiter.
package kband_lw_mem_pkg;

    localparam int ADDR_W_DEF   = 13;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_HOLD_DEF = 16;
    localparam int HOLD_MIN     = 1;
    localparam int HOLD_MAX     = 255;
    localparam int HOLD_W       = 8;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_pend_t;

endpackage

// File: rtl/kband_rr_hold_grant.sv
// Sticky round-robin grant with a bounded hold: owner/hold_cnt state plus combinational grant.
module kband_rr_hold_grant
    import kband_lw_mem_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic       grant_vld,
    output req_id_t    grant_id
);

    if (MAX_HOLD < HOLD_MIN || MAX_HOLD > HOLD_MAX) begin : g_hold_range_bad
        $error("kband_rr_hold_grant: MAX_HOLD out of range 1..255");
    end

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

    req_id_t           owner;
    req_id_t           other;
    logic [HOLD_W-1:0] hold_cnt;
    logic              req_own;
    logic              req_oth;

    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        return (v == '1) ? v : v + HOLD_W'(1);
    endfunction

    always_comb begin
        other     = req_id_t'(~owner);
        req_own   = req[owner];
        req_oth   = req[other];
        grant_vld = 1'b0;
        grant_id  = owner;
        if (req_own && (!req_oth || hold_cnt < HOLD_LIM)) begin
            grant_vld = 1'b1;
            grant_id  = owner;
        end else if (req_oth) begin
            grant_vld = 1'b1;
            grant_id  = other;
        end
    end

    // hold_cnt only advances while the non-owner is actually waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= REQ0;
            hold_cnt <= '0;
        end else if (grant_vld) begin
            if (grant_id != owner) begin
                owner    <= grant_id;
                hold_cnt <= req_own ? HOLD_W'(1) : '0;
            end else if (req_oth) begin
                hold_cnt <= sat_inc(hold_cnt);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/kband_lw_mem_arbiter.sv
// Two-requester Avalon-MM arbiter in front of the single-port 8192x32 memory (read latency 1).
module kband_lw_mem_arbiter
    import kband_lw_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int BE_W = DATA_W / 8;

    logic [1:0]        req;
    logic              grant_vld;
    req_id_t           grant_id;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;
    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    rd_pend_t          rd_pend_p1;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    kband_rr_hold_grant #(.MAX_HOLD(MAX_HOLD)) u_grant (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    assign accept         = grant_vld & ~reset;
    assign m0_waitrequest = reset | ~(grant_vld & (grant_id == REQ0));
    assign m1_waitrequest = reset | ~(grant_vld & (grant_id == REQ1));

    always_comb begin
        sel_addr  = m0_address;
        sel_wdata = m0_writedata;
        sel_be    = m0_byteenable;
        sel_read  = m0_read;
        sel_write = m0_write;
        if (grant_id == REQ1) begin
            sel_addr  = m1_address;
            sel_wdata = m1_writedata;
            sel_be    = m1_byteenable;
            sel_read  = m1_read;
            sel_write = m1_write;
        end
    end

    // Stage p0 -> memory: last granted command is held while nobody is granted
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            be_q    <= sel_be;
        end
    end

    assign mem_address    = accept ? sel_addr  : addr_q;
    assign mem_writedata  = accept ? sel_wdata : wdata_q;
    assign mem_byteenable = accept ? sel_be    : be_q;
    assign mem_chipselect = accept;
    assign mem_write      = accept & sel_write;
    assign mem_clken      = 1'b1;

    // Stage p1: read return tag, aligned with the memory's one-cycle latency
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_p1 <= '0;
        end else begin
            rd_pend_p1.valid <= accept & sel_read & ~sel_write;
            rd_pend_p1.id    <= grant_id;
        end
    end

    assign m0_readdatavalid = ~reset & rd_pend_p1.valid & (rd_pend_p1.id == REQ0);
    assign m1_readdatavalid = ~reset & rd_pend_p1.valid & (rd_pend_p1.id == REQ1);
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

    a_m0_rw_excl : assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
    a_m1_rw_excl : assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));

endmodule

// File: tb/tb_kband_lw_mem_arbiter.sv
// Directed bench for kband_lw_mem_arbiter with a behavioural 1-cycle-latency memory, MAX_HOLD = 4.
module tb_kband_lw_mem_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] m0_address, m1_address;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_writedata;
    logic [BW-1:0] mem_byteenable;
    logic [DW-1:0] mem_readdata;

    logic [DW-1:0] mem_model [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    kband_lw_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_byteenable   (mem_byteenable),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    // Behavioural single-port memory: byte-lane writes, registered reads
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < BW; b++)
                    if (mem_byteenable[b]) mem_model[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= mem_model[mem_address];
            end
        end
    end

    function automatic logic [DW-1:0] preload(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    task automatic idle();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0; m0_byteenable = '1;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0; m1_byteenable = '1;
    endtask

    task automatic reset_pulse();
        @(negedge clk); idle(); reset = 1;
        @(negedge clk); reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); idle(); reset = 1; m0_read = 1; m1_write = 1;
        @(negedge clk); #1;
        checks++; if (m0_waitrequest !== 1'b1) begin failures++; $display("FAIL rst_m0_wait got=%b exp=1", m0_waitrequest); end
        checks++; if (m1_waitrequest !== 1'b1) begin failures++; $display("FAIL rst_m1_wait got=%b exp=1", m1_waitrequest); end
        checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin failures++;
            $display("FAIL rst_rdv got=%b%b exp=00", m0_readdatavalid, m1_readdatavalid); end
        checks++; if (mem_chipselect !== 1'b0) begin failures++; $display("FAIL rst_cs got=%b exp=0", mem_chipselect); end
        idle(); reset = 0;
    endtask

    task automatic test_single();
        @(negedge clk); idle(); m0_write = 1; m0_address = 13'h0005; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
        #1;
        checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("FAIL single_wr_wait got=%b exp=0", m0_waitrequest); end
        @(negedge clk); m0_write = 0; m0_read = 1;
        #1;
        checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("FAIL single_rd_wait got=%b exp=0", m0_waitrequest); end
        @(negedge clk); idle(); #1;
        checks++; if (m0_readdatavalid !== 1'b1) begin failures++; $display("FAIL single_rdv got=%b exp=1", m0_readdatavalid); end
        checks++; if (m0_readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", m0_readdata); end
        checks++; if (m1_readdatavalid !== 1'b0) begin failures++; $display("FAIL single_m1_quiet got=%b exp=0", m1_readdatavalid); end
        @(negedge clk); #1;
        checks++; if (m0_readdatavalid !== 1'b0) begin failures++; $display("FAIL single_rdv_once got=%b exp=0", m0_readdatavalid); end
    endtask

    task automatic test_byte_lanes();
        @(negedge clk); idle(); m1_write = 1; m1_address = 13'h1FFF; m1_writedata = 32'h11223344; m1_byteenable = 4'hF;
        @(negedge clk); m1_writedata = 32'hAA000000; m1_byteenable = 4'h8;
        @(negedge clk); m1_write = 0; m1_read = 1; m1_byteenable = 4'hF;
        @(negedge clk); idle(); #1;
        checks++; if (m1_readdatavalid !== 1'b1) begin failures++; $display("FAIL be_rdv got=%b exp=1", m1_readdatavalid); end
        checks++; if (m1_readdata !== 32'hAA223344) begin failures++; $display("FAIL be_data got=%h exp=aa223344", m1_readdata); end
        checks++; if (m0_readdatavalid !== 1'b0) begin failures++; $display("FAIL be_m0_quiet got=%b exp=0", m0_readdatavalid); end
    endtask

    task automatic test_rdw();
        @(negedge clk); idle(); m0_write = 1; m0_address = 13'h0010; m0_writedata = 32'h13572468;
        @(negedge clk); idle(); m1_read = 1; m1_address = 13'h0010;
        @(negedge clk); idle(); #1;
        checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h13572468) begin failures++;
            $display("FAIL rdw got=%b/%h exp=1/13572468", m1_readdatavalid, m1_readdata); end
    endtask

    task automatic test_contention();
        int n0 = 0;
        int n1 = 0;
        logic prev_vld = 1'b0;
        logic prev_id  = 1'b0;
        int   prev_a   = 0;
        reset_pulse();
        for (int c = 0; c < 17; c++) begin
            logic exp_m1;
            if (c > 0) @(negedge clk);
            exp_m1 = ((c / MH) % 2) == 1;
            m0_read = (c < 16); m1_read = (c < 16);
            m0_address = AW'(12'h100 + n0); m1_address = AW'(12'h200 + n1);
            #1;
            if (c < 16) begin
                checks++; if (m0_waitrequest !== exp_m1 || m1_waitrequest !== !exp_m1) begin failures++;
                    $display("FAIL cont_grant c=%0d got wait=%b%b exp=%b%b", c, m1_waitrequest, m0_waitrequest, !exp_m1, exp_m1); end
            end
            if (prev_vld) begin
                checks++;
                if (prev_id ? (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdata !== preload(prev_a))
                            : (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== preload(prev_a))) begin
                    failures++;
                    $display("FAIL cont_ret c=%0d got rdv=%b%b d=%h exp id=%0d d=%h", c, m1_readdatavalid, m0_readdatavalid,
                             mem_readdata, prev_id, preload(prev_a));
                end
            end
            prev_vld = (c < 16);
            prev_id  = exp_m1;
            prev_a   = exp_m1 ? 32'h200 + n1 : 32'h100 + n0;
            if (c < 16) begin
                if (exp_m1) n1++; else n0++;
            end
        end
        idle();
    endtask

    task automatic test_handover();
        reset_pulse();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            m0_read = 1; m0_address = AW'(c);
            #1;
            checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("FAIL ho_solo c=%0d got=%b exp=0", c, m0_waitrequest); end
        end
        for (int c = 0; c < 10; c++) begin
            logic exp_m1;
            @(negedge clk);
            m1_read = 1;
            exp_m1 = (c >= MH) && (c < 2 * MH);
            #1;
            checks++; if (m1_waitrequest !== !exp_m1 || m0_waitrequest !== exp_m1) begin failures++;
                $display("FAIL ho_grant c=%0d got wait=%b%b exp=%b%b", c, m1_waitrequest, m0_waitrequest, !exp_m1, exp_m1); end
        end
        @(negedge clk); idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk); idle(); m0_read = 1; m0_address = 13'h0001;
        @(negedge clk); idle(); m1_read = 1; m1_address = 13'h0002; #1;
        checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== preload(1)) begin failures++;
            $display("FAIL b2b_m0 got=%b/%h exp=1/%h", m0_readdatavalid, m0_readdata, preload(1)); end
        checks++; if (m1_waitrequest !== 1'b0) begin failures++; $display("FAIL b2b_m1_wait got=%b exp=0", m1_waitrequest); end
        @(negedge clk); idle(); #1;
        checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== preload(2) || m0_readdatavalid !== 1'b0) begin failures++;
            $display("FAIL b2b_m1 got=%b%b/%h exp=10/%h", m1_readdatavalid, m0_readdatavalid, m1_readdata, preload(2)); end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk); idle(); m0_read = 1; m0_address = 13'h0003;
        @(negedge clk); idle(); reset = 1; #1;
        checks++; if (m0_readdatavalid !== 1'b0) begin failures++; $display("FAIL rmr_rdv got=%b exp=0", m0_readdatavalid); end
        checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin failures++;
            $display("FAIL rmr_wait got=%b%b exp=11", m1_waitrequest, m0_waitrequest); end
        @(negedge clk); reset = 0; m0_read = 1; m1_read = 1; #1;
        checks++; if (m0_readdatavalid !== 1'b0) begin failures++; $display("FAIL rmr_rdv_after got=%b exp=0", m0_readdatavalid); end
        checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin failures++;
            $display("FAIL rmr_contest got=%b%b exp=10", m1_waitrequest, m0_waitrequest); end
        @(negedge clk); idle();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem_model[i] = preload(i);
        mem_readdata = '0;
        reset = 1;
        idle();
        test_reset();
        test_single();
        test_byte_lanes();
        test_rdw();
        test_contention();
        test_handover();
        test_back_to_back();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
